// File: rtl/ca_pkg.sv
// Shared constants, types and helpers for the cellular-automaton frame-buffer writer.
// Cell c of a row is held in bit c of row_t; in the frame buffer it sits in
// word c/16, bit 15-(c%16), so cell 0 is the MSB of word 0.
package ca_pkg;

  localparam int ROW_CELLS     = 512;
  localparam int WORD_W        = 16;
  localparam int WORDS_PER_ROW = 32;
  localparam int BUF_ROWS      = 256;
  localparam int ADDR_W        = 13;

  // One generation: bit c is cell c.
  typedef logic [ROW_CELLS-1:0] row_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WRITE_ROW,
    COMPUTE,
    WAIT_FRAME,
    DONE
  } state_t;

  // Pack the 16 cells of word w into buffer order (lowest cell in the MSB).
  function automatic logic [WORD_W-1:0] row_word(input row_t row, input logic [4:0] w);
    logic [WORD_W-1:0] word;
    word = '0;
    for (int k = 0; k < WORD_W; k++) begin
      word[WORD_W-1-k] = row[{w, 4'(k)}];
    end
    return word;
  endfunction

endpackage

// File: rtl/ca_rule_next.sv
// Combinational next generation of a 512-cell elementary cellular automaton.
// next[i] = rule[{cell[i-1], cell[i], cell[i+1]}].
// Optional macro CA_WRAP_EN: when defined the row is a ring (cell -1 is cell 511,
// cell 512 is cell 0); when undefined both edge neighbours read as 0.
module ca_rule_next
  import ca_pkg::*;
(
  input  logic [7:0]           rule,
  input  logic [ROW_CELLS-1:0] row,
  output logic [ROW_CELLS-1:0] next_row
);

  logic left_edge;   // neighbour to the left of cell 0
  logic right_edge;  // neighbour to the right of cell 511

`ifdef CA_WRAP_EN
  assign left_edge  = row[ROW_CELLS-1];
  assign right_edge = row[0];
`else
  assign left_edge  = 1'b0;
  assign right_edge = 1'b0;
`endif

  // ext[i+1] is cell i; ext[0] and ext[ROW_CELLS+1] are the edge neighbours.
  logic [ROW_CELLS+1:0] ext;
  assign ext = {right_edge, row, left_edge};

  // Each cell looks up its 3-cell neighbourhood in the rule byte.
  generate
    for (genvar gi = 0; gi < ROW_CELLS; gi++) begin : g_cell
      assign next_row[gi] = rule[{ext[gi], ext[gi+1], ext[gi+2]}];
    end
  endgenerate

endmodule

// File: rtl/ca_gen_scheduler.sv
// Generation scheduler: clears the 512x256 one-bit frame buffer, seeds a single
// live cell, then writes one automaton generation per buffer row, pacing
// generations to frame_start and only touching the buffer while video_on is low.
// Optional macro CA_WRAP_EN (used by ca_rule_next) selects a toroidal row.
module ca_gen_scheduler
  import ca_pkg::*;
#(
  parameter int GENS_PER_FRAME = 1,
  parameter int SCROLL         = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rule,
  input  logic [8:0]  seed_pos,
  input  logic        frame_start,
  input  logic        video_on,
  output logic        mem_we,
  output logic [12:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [7:0]  row_offset,
  output logic        busy,
  output logic        done
);

  localparam logic [15:0] GENS_LIM = 16'(GENS_PER_FRAME);

  state_t      state_reg,      state_next;
  logic [7:0]  rule_reg,       rule_next;
  row_t        row_reg,        row_next;
  logic [7:0]  wr_row_reg,     wr_row_next;
  logic [4:0]  word_reg,       word_next;
  logic [12:0] clr_addr_reg,   clr_addr_next;
  logic [15:0] gen_cnt_reg,    gen_cnt_next;
  logic        wrapped_reg,    wrapped_next;
  logic [7:0]  row_offset_reg, row_offset_next;

  row_t next_row;

  ca_rule_next u_rule_next (
    .rule     (rule_reg),
    .row      (row_reg),
    .next_row (next_row)
  );

  // State and datapath registers; reset returns everything to an idle, empty run.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      rule_reg       <= '0;
      row_reg        <= '0;
      wr_row_reg     <= '0;
      word_reg       <= '0;
      clr_addr_reg   <= '0;
      gen_cnt_reg    <= '0;
      wrapped_reg    <= 1'b0;
      row_offset_reg <= '0;
    end else begin
      state_reg      <= state_next;
      rule_reg       <= rule_next;
      row_reg        <= row_next;
      wr_row_reg     <= wr_row_next;
      word_reg       <= word_next;
      clr_addr_reg   <= clr_addr_next;
      gen_cnt_reg    <= gen_cnt_next;
      wrapped_reg    <= wrapped_next;
      row_offset_reg <= row_offset_next;
    end
  end

  // Next-state logic and buffer port; writes only happen while video_on is low,
  // and a stalled write keeps its address and data because the counters hold.
  always_comb begin
    state_next      = state_reg;
    rule_next       = rule_reg;
    row_next        = row_reg;
    wr_row_next     = wr_row_reg;
    word_next       = word_reg;
    clr_addr_next   = clr_addr_reg;
    gen_cnt_next    = gen_cnt_reg;
    wrapped_next    = wrapped_reg;
    row_offset_next = row_offset_reg;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;

    if (start) begin
      // A start always restarts the run; any partly written row is wiped by CLEAR.
      state_next           = CLEAR;
      rule_next            = rule;
      row_next             = '0;
      row_next[seed_pos]   = 1'b1;
      wr_row_next          = '0;
      word_next            = '0;
      clr_addr_next        = '0;
      gen_cnt_next         = '0;
      wrapped_next         = 1'b0;
      row_offset_next      = '0;
    end else begin
      case (state_reg)
        CLEAR: begin
          mem_we   = ~video_on;
          mem_addr = clr_addr_reg;
          if (!video_on) begin
            clr_addr_next = clr_addr_reg + 13'd1;
            if (clr_addr_reg == 13'h1FFF) begin
              state_next = WRITE_ROW;
              word_next  = '0;
            end
          end
        end

        WRITE_ROW: begin
          mem_we    = ~video_on;
          mem_addr  = {wr_row_reg, word_reg};
          mem_wdata = row_word(row_reg, word_reg);
          if (!video_on) begin
            word_next = word_reg + 5'd1;
            if (word_reg == 5'd31) begin
              // The seed row counts as the first generation of frame 0.
              gen_cnt_next = gen_cnt_reg + 16'd1;
              if ((gen_cnt_reg + 16'd1) < GENS_LIM) begin
                state_next = COMPUTE;
              end else begin
                state_next = WAIT_FRAME;
              end
            end
          end
        end

        COMPUTE: begin
          if (SCROLL == 0 && wr_row_reg == 8'hFF) begin
            state_next = DONE;
          end else begin
            row_next    = next_row;
            wr_row_next = wr_row_reg + 8'd1;
            word_next   = '0;
            state_next  = WRITE_ROW;
            // After the first wrap the oldest row is the one just past the new write row.
            if (SCROLL != 0 && (wrapped_reg || wr_row_reg == 8'hFF)) begin
              wrapped_next    = 1'b1;
              row_offset_next = wr_row_reg + 8'd2;
            end
          end
        end

        WAIT_FRAME: begin
          if (frame_start) begin
            gen_cnt_next = '0;
            state_next   = COMPUTE;
          end
        end

        IDLE, DONE: begin
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign row_offset = row_offset_reg;
  assign busy       = (state_reg != IDLE) && (state_reg != DONE);
  assign done       = (state_reg == DONE);

endmodule

// File: tb/tb_ca_gen_scheduler.sv
// Self-checking bench for ca_gen_scheduler: hand-computed vector table, random
// rule/seed runs against a behavioural automaton model, stalled writes, and a
// long scrolling run beside a non-scrolling instance.
`timescale 1ns/1ps
module tb_ca_gen_scheduler;

  localparam int NWORDS = 8192;
`ifdef CA_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef logic [511:0] row_m;

  typedef struct {
    logic [7:0]  rule;
    logic [8:0]  seed;
    int          frames;
    int          row;
    int          word;
    logic [15:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, start, frame_start, video_on;
  logic [7:0]  rule;
  logic [8:0]  seed_pos;

  logic        we_a, we_b;
  logic [12:0] addr_a, addr_b;
  logic [15:0] wdata_a, wdata_b;
  logic [7:0]  off_a, off_b;
  logic        busy_a, busy_b, done_a, done_b;

  always #5 clk = ~clk;

  ca_gen_scheduler #(.GENS_PER_FRAME(1), .SCROLL(1)) dut (
    .clk(clk), .reset(reset), .start(start), .rule(rule), .seed_pos(seed_pos),
    .frame_start(frame_start), .video_on(video_on),
    .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
    .row_offset(off_a), .busy(busy_a), .done(done_a)
  );

  ca_gen_scheduler #(.GENS_PER_FRAME(1), .SCROLL(0)) dut_ns (
    .clk(clk), .reset(reset), .start(start), .rule(rule), .seed_pos(seed_pos),
    .frame_start(frame_start), .video_on(video_on),
    .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
    .row_offset(off_b), .busy(busy_b), .done(done_b)
  );

  // Frame-buffer model fed by the scrolling instance's write port.
  logic [15:0] buf_a [NWORDS];
  int wcnt_a = 0, wcnt_b = 0, bus_viol = 0;
  int checks = 0, errors = 0;
  int cyc = 0;
  logic stall_en = 1'b0;

  // Inputs only change #1 after posedge, so the negedge view is what the next edge writes.
  always @(negedge clk) begin
    if (we_a) begin
      buf_a[addr_a] = wdata_a;
      wcnt_a++;
      if (video_on) bus_viol++;
    end
    if (we_b) begin
      wcnt_b++;
      if (video_on) bus_viol++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    video_on = stall_en ? ((cyc % 16) < 10) : 1'b0;
  endtask

  // Behavioural automaton step straight from the rule definition.
  function automatic row_m model_next(input row_m c, input logic [7:0] r);
    row_m n;
    int l, m, rt;
    n = '0;
    for (int i = 0; i < 512; i++) begin
      m  = int'(c[i]);
      l  = (i == 0)   ? (WRAP ? int'(c[511]) : 0) : int'(c[i-1]);
      rt = (i == 511) ? (WRAP ? int'(c[0])   : 0) : int'(c[i+1]);
      n[i] = r[l*4 + m*2 + rt];
    end
    return n;
  endfunction

  function automatic logic [15:0] model_word(input row_m c, input int w);
    logic [15:0] x;
    for (int k = 0; k < 16; k++) x[15-k] = c[16*w + k];
    return x;
  endfunction

  logic [7:0] cur_rule;
  row_m       model_row;
  int         cur_frames;

  task automatic check_row(input int brow, input row_m exp, input string name);
    for (int w = 0; w < 32; w++)
      chk($sformatf("%s row%0d word%0d", name, brow, w), 32'(buf_a[brow*32 + w]), 32'(model_word(exp, w)));
    $display("row check %s: buffer row %0d compared", name, brow);
  endtask

  task automatic wait_writes(input int target, input string what);
    int n;
    n = 0;
    while (wcnt_a < target && n < 20000) begin
      tick();
      n++;
    end
    chk({what, " write count"}, 32'(wcnt_a), 32'(target));
  endtask

  task automatic start_run(input logic [7:0] r, input logic [8:0] s);
    int nz;
    stall_en = 1'b0;
    for (int i = 0; i < NWORDS; i++) buf_a[i] = 16'hDEAD;
    wcnt_a = 0;
    wcnt_b = 0;
    rule = r; seed_pos = s; start = 1'b1;
    tick();
    start = 1'b0;
    rule = ~r; seed_pos = ~s;   // sampled only at start
    cur_rule = r; model_row = '0; model_row[s] = 1'b1; cur_frames = 0;
    $display("run start: rule=%0d seed=%0d", r, s);
    repeat (100) tick();
    frame_start = 1'b1; tick(); frame_start = 1'b0;   // arrives during CLEAR
    wait_writes(NWORDS + 32, "seed row");
    repeat (40) tick();
    chk("frame_start during clear dropped", 32'(wcnt_a), 32'(NWORDS + 32));
    nz = 0;
    for (int i = 32; i < NWORDS; i++) if (buf_a[i] != 16'h0000) nz++;
    chk("cleared words nonzero", 32'(nz), 32'd0);
    check_row(0, model_row, "seed");
  endtask

  task automatic next_frame();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    cur_frames++;
    model_row = model_next(model_row, cur_rule);
    wait_writes(NWORDS + 32*(cur_frames + 1), $sformatf("frame %0d", cur_frames));
    $display("frame %0d: writes=%0d row_offset=%0d", cur_frames, wcnt_a, off_a);
  endtask

  vec_t vecs[8];
  row_m rgen [6];
  row_m sgen [261];

  initial begin
    bit have_run;
    logic [7:0] rr;
    logic [8:0] ss;

    reset = 1'b1; start = 1'b0; frame_start = 1'b0; video_on = 1'b0;
    rule = '0; seed_pos = '0;

    vecs[0] = '{8'd90, 9'd256, 0, 0, 16, 16'h8000};
    vecs[1] = '{8'd90, 9'd256, 1, 1, 15, 16'h0001};
    vecs[2] = '{8'd90, 9'd256, 1, 1, 16, 16'h4000};
    vecs[3] = '{8'd90, 9'd256, 1, 1, 0,  16'h0000};
    vecs[4] = '{8'd90, 9'd511, 1, 1, 31, 16'h0002};
    vecs[5] = '{8'd90, 9'd511, 1, 1, 0,  WRAP ? 16'h8000 : 16'h0000};
    vecs[6] = '{8'd30, 9'd0,   1, 1, 0,  16'hC000};
    vecs[7] = '{8'd30, 9'd0,   1, 1, 31, WRAP ? 16'h0001 : 16'h0000};

    // Reset state and idle behaviour.
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    chk("reset mem_we", 32'(we_a), 32'd0);
    chk("reset mem_addr", 32'(addr_a), 32'd0);
    chk("reset mem_wdata", 32'(wdata_a), 32'd0);
    chk("reset row_offset", 32'(off_a), 32'd0);
    chk("reset busy", 32'(busy_a), 32'd0);
    chk("reset done", 32'(done_b), 32'd0);
    repeat (50) tick();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    repeat (50) tick();
    chk("idle writes", 32'(wcnt_a), 32'd0);
    chk("idle busy", 32'(busy_a), 32'd0);
    $display("idle: 100 cycles, writes=%0d", wcnt_a);

    // Table of hand-computed buffer words.
    have_run = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!have_run || vecs[i].rule != cur_rule || model_row == '0 ||
          vecs[i].frames < cur_frames || vecs[i].seed != ss) begin
        start_run(vecs[i].rule, vecs[i].seed);
        ss = vecs[i].seed;
        have_run = 1'b1;
      end
      while (cur_frames < vecs[i].frames) next_frame();
      chk($sformatf("vec%0d rule%0d seed%0d row%0d word%0d", i, vecs[i].rule, vecs[i].seed,
                    vecs[i].row, vecs[i].word),
          32'(buf_a[vecs[i].row*32 + vecs[i].word]), 32'(vecs[i].exp));
      $display("vector %0d: word=%04h", i, buf_a[vecs[i].row*32 + vecs[i].word]);
    end

    // Reset during a clear write.
    rule = 8'd90; seed_pos = 9'd3; start = 1'b1; tick(); start = 1'b0;
    repeat (20) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    @(negedge clk);
    chk("mem_we after mid-write reset", 32'(we_a), 32'd0);
    chk("busy after mid-write reset", 32'(busy_a), 32'd0);
    $display("mid-write reset: mem_we=%0d busy=%0d", we_a, busy_a);
    tick();

    // Random rules and seeds; the second run stalls writes with video_on.
    for (int n = 0; n < 2; n++) begin
      rr = 8'($urandom);
      ss = 9'($urandom);
      start_run(rr, ss);
      rgen[0] = model_row;
      stall_en = (n == 1);
      for (int f = 1; f < 6; f++) begin
        next_frame();
        rgen[f] = model_row;
      end
      stall_en = 1'b0;
      tick();
      for (int f = 0; f < 6; f++) check_row(f, rgen[f], $sformatf("random%0d", n));
      chk("random row_offset", 32'(off_a), 32'd0);
    end

    // Long run: scrolling instance wraps, non-scrolling instance stops.
    start_run(8'd90, 9'd256);
    sgen[0] = model_row;
    for (int p = 1; p <= 260; p++) begin
      next_frame();
      sgen[p] = model_row;
      if (p == 255) chk("row_offset before wrap", 32'(off_a), 32'd0);
      if (p == 256) begin
        chk("row_offset at wrap", 32'(off_a), 32'd1);
        chk("noscroll done", 32'(done_b), 32'd1);
        chk("noscroll busy", 32'(busy_b), 32'd0);
        chk("scroll done", 32'(done_a), 32'd0);
      end
    end
    chk("row_offset after row 4", 32'(off_a), 32'd5);
    chk("noscroll writes stop", 32'(wcnt_b), 32'(NWORDS + 256*32));
    chk("noscroll still done", 32'(done_b), 32'd1);
    for (int r = 0; r < 5; r++) check_row(r, sgen[256 + r], "wrapped");
    check_row(5, sgen[5], "scroll");
    check_row(255, sgen[255], "scroll");

    chk("writes while video_on", 32'(bus_viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
